// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Lets up to NREQ requesters (n, phi, modular-exponent generators, ...) share
// one multiplier_sm instance.
//
// Flow:
//   IDLE -> BUSY: a winner is picked and its operands are registered into the
//                 multiplier, together with mult_ready.
//   BUSY -> ACK : on mult_done the product is latched and done[g] is raised.
//   ACK  -> IDLE: once req[g] and mult_done are both low, done and gnt clear
//                 and the round-robin pointer moves past g.
// Every output comes straight from a flop.
//
// Configuration macro:
//   MULT_ARB_FIXED_PRIO_EN - if defined, fixed priority (lowest index wins)
//                            and no pointer. If undefined (default),
//                            round-robin starting from the pointer.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req[NREQ]             per-requester request level
//   in1_flat, in2_flat    operands, requester i at [i*WIDTH +: WIDTH]
//   gnt[NREQ]             one-hot grant, held for the whole transaction
//   done[NREQ]            one-hot completion, held until req[g] drops
//   result[WIDTH]         last product, stable while done is high
//   busy                  state is not IDLE
//   mult_ready, m_in1/2   towards multiplier_sm
//   mult_out, mult_done   from multiplier_sm
// -----------------------------------------------------------------------------
module mult_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] in1_flat,
    input  logic [NREQ*WIDTH-1:0] in2_flat,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  busy,
    output logic                  mult_ready,
    output logic [WIDTH-1:0]      m_in1,
    output logic [WIDTH-1:0]      m_in2,
    input  logic [WIDTH-1:0]      mult_out,
    input  logic                  mult_done
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              busy_q, busy_d;
    logic              mult_ready_q, mult_ready_d;
    logic [WIDTH-1:0]  m_in1_q, m_in1_d;
    logic [WIDTH-1:0]  m_in2_q, m_in2_d;

    logic [NREQ-1:0]   win_oh;
    logic [WIDTH-1:0]  sel_in1, sel_in2;
    logic              issue_go, finish_go, release_go;

    // Transition strobes shared by the next-state and output processes.
    // Only the granted requester's req can hold the arbiter in ACK.
    assign issue_go   = (state_q == S_IDLE) && (|req);
    assign finish_go  = (state_q == S_BUSY) && mult_done;
    assign release_go = (state_q == S_ACK) && !(|(req & gnt_q)) && !mult_done;

`ifdef MULT_ARB_FIXED_PRIO_EN
    // Isolate the lowest set request bit.
    assign win_oh = req & (~req + NREQ'(1));
`else
    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic [IDX_W-1:0] win_idx;
    logic             found;
    int               idx;

    // Scan from the pointer upwards, wrapping; the first asserted req wins.
    always_comb begin : rr_pick
        // NOTE: every variable gets a default before any branch, so no
        // path through this block leaves a value unassigned (no latch).
        win_idx = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
        win_oh = NREQ'(1) << win_idx;
    end

    always_comb begin : rr_pointer
        g_d   = issue_go ? win_idx : g_q;
        ptr_d = ptr_q;
        if (release_go) ptr_d = (g_q == IDX_W'(NREQ - 1)) ? '0 : g_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin : rr_regs
        if (!reset_n) begin
            ptr_q <= '0;
            g_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            g_q   <= g_d;
        end
    end
`endif

    // One-hot operand mux; only meaningful while a req bit is set.
    always_comb begin : operand_mux
        sel_in1 = '0;
        sel_in2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                sel_in1 = sel_in1 | in1_flat[i*WIDTH +: WIDTH];
                sel_in2 = sel_in2 | in2_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    // State register (all flops of the block)
    always_ff @(posedge clk or negedge reset_n) begin : state_reg
        if (!reset_n) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            done_q       <= '0;
            result_q     <= '0;
            busy_q       <= 1'b0;
            mult_ready_q <= 1'b0;
            m_in1_q      <= '0;
            m_in2_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            result_q     <= result_d;
            busy_q       <= busy_d;
            mult_ready_q <= mult_ready_d;
            m_in1_q      <= m_in1_d;
            m_in2_q      <= m_in2_d;
        end
    end

    // Next-state logic
    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (issue_go)   state_d = S_BUSY;
            S_BUSY:  if (finish_go)  state_d = S_ACK;
            S_ACK:   if (release_go) state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Output logic: every registered output holds unless a strobe fires.
    always_comb begin : output_logic
        gnt_d        = gnt_q;
        done_d       = done_q;
        result_d     = result_q;
        mult_ready_d = mult_ready_q;
        m_in1_d      = m_in1_q;
        m_in2_d      = m_in2_q;
        if (issue_go) begin
            gnt_d        = win_oh;
            m_in1_d      = sel_in1;
            m_in2_d      = sel_in2;
            mult_ready_d = 1'b1;
        end
        if (finish_go) begin
            result_d     = mult_out;
            mult_ready_d = 1'b0;
            done_d       = gnt_q;
        end
        if (release_go) begin
            done_d = '0;
            gnt_d  = '0;
        end
        busy_d = (state_d != S_IDLE);
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign result     = result_q;
    assign busy       = busy_q;
    assign mult_ready = mult_ready_q;
    assign m_in1      = m_in1_q;
    assign m_in2      = m_in2_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//
// Directed bench for mult_arbiter. The bench plays multiplier_sm by hand.
// Each expected transaction (winner index, operands) is queued when its
// request is driven, and is checked when the grant and the done appear.
// Inputs change just after a falling edge, and outputs are read on a falling
// edge. Expected grant order follows MULT_ARB_FIXED_PRIO_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] in1_flat, in2_flat;
    logic [NREQ-1:0]       gnt, done;
    logic [WIDTH-1:0]      result;
    logic                  busy, mult_ready;
    logic [WIDTH-1:0]      m_in1, m_in2;
    logic [WIDTH-1:0]      mult_out;
    logic                  mult_done;

    mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .in1_flat   (in1_flat),
        .in2_flat   (in2_flat),
        .gnt        (gnt),
        .done       (done),
        .result     (result),
        .busy       (busy),
        .mult_ready (mult_ready),
        .m_in1      (m_in1),
        .m_in2      (m_in2),
        .mult_out   (mult_out),
        .mult_done  (mult_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in1_flat[i*WIDTH +: WIDTH] = a;
        in2_flat[i*WIDTH +: WIDTH] = b;
    endtask

    // Queue a request: drive operands, raise req, remember what must come back.
    task automatic request(input int i, input int exp_idx, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
        exp_t e;
        set_ops(i, a, b);
        req[i] = 1'b1;
        e.idx = exp_idx;
        e.a   = a;
        e.b   = b;
        sb.push_back(e);
    endtask

    // One complete transaction. The grant must be visible at the first falling
    // edge. drop_early drops req in BUSY and keeps mult_done high one cycle
    // into ACK. stall holds req for that many cycles after done.
    task automatic run_txn(input bit drop_early, input int stall);
        exp_t             e;
        logic [NREQ-1:0]  oh;
        logic [WIDTH-1:0] prod;
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed=empty expected=entry");
            return;
        end
        e    = sb.pop_front();
        oh   = NREQ'(1) << e.idx;
        prod = e.a * e.b;
        check("gnt_issue", gnt, oh);
        check("mult_ready_issue", mult_ready, 1'b1);
        check("m_in1_issue", m_in1, e.a);
        check("m_in2_issue", m_in2, e.b);
        check("busy_issue", busy, 1'b1);
        // Operands are sampled only at issue; disturbing them must not leak.
        in1_flat[e.idx*WIDTH +: WIDTH] = ~e.a;
        if (drop_early) req[e.idx] = 1'b0;
        @(negedge clk);
        check("m_in1_hold", m_in1, e.a);
        check("mult_ready_hold", mult_ready, 1'b1);
        mult_out  = prod;
        mult_done = 1'b1;
        @(negedge clk);
        check("done_set", done, oh);
        check("result", result, prod);
        check("mult_ready_clr", mult_ready, 1'b0);
        check("gnt_in_ack", gnt, oh);
        mult_out = ~prod;
        if (drop_early) begin
            @(negedge clk);
            check("done_wait_mult_done", done, oh);
        end
        mult_done = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_done", done, oh);
            check("stall_result", result, prod);
            check("stall_gnt", gnt, oh);
        end
        req[e.idx] = 1'b0;
        @(negedge clk);
        check("done_clr", done, '0);
        check("gnt_clr", gnt, '0);
        check("busy_clr", busy, 1'b0);
    endtask

    function automatic int fair_idx(input int k);
`ifdef MULT_ARB_FIXED_PRIO_EN
        return 0;
`else
        return k % NREQ;
`endif
    endfunction

    initial begin
        reset_n   = 1'b0;
        req       = '0;
        in1_flat  = '0;
        in2_flat  = '0;
        mult_out  = '0;
        mult_done = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, '0);
        check("rst_done", done, '0);
        check("rst_result", result, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_mult_ready", mult_ready, 1'b0);
        check("rst_m_in1", m_in1, '0);
        check("rst_m_in2", m_in2, '0);
        reset_n = 1'b1;

        // Contention 0101: 0 first, stalled in ACK with req[2] waiting, then 2
        request(0, 0, 32'h1234_5678, 32'h9abc_def0);
        request(2, 2, 32'd1000, 32'd3);
        run_txn(1'b0, 2);
        run_txn(1'b0, 0);

        // Re-raise 0101: pointer wrapped to 3, so 0 wins again
        request(0, 0, 32'd12, 32'd12);
        request(2, 2, 32'hffff_ffff, 32'hffff_ffff);
        run_txn(1'b0, 0);
        run_txn(1'b0, 0);

        // Single requester 1 (7*9), then requester 3 dropping req during BUSY
        request(1, 1, 32'd7, 32'd9);
        run_txn(1'b0, 0);
        request(3, 3, 32'd65536, 32'd65537);
        run_txn(1'b1, 0);

        // Fairness: all four held, each drops after done and re-raises
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NREQ; i++) set_ops(i, 32'(100 * k + i + 3), 32'(11 + i + k));
            request(fair_idx(k), fair_idx(k), 32'(100 * k + fair_idx(k) + 3),
                    32'(11 + fair_idx(k) + k));
            req = '1;
            run_txn(1'b0, 0);
        end
        req = '0;

        // Abort: reset while BUSY on requester 2
        set_ops(2, 32'd5, 32'd6);
        req[2] = 1'b1;
        @(negedge clk);
        check("abort_gnt", gnt, 4'b0100);
        @(negedge clk);
        check("abort_busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_gnt_clr", gnt, '0);
        check("abort_done_clr", done, '0);
        check("abort_result_clr", result, '0);
        check("abort_busy_clr", busy, 1'b0);
        check("abort_mult_ready_clr", mult_ready, 1'b0);
        check("abort_m_in1_clr", m_in1, '0);
        check("abort_m_in2_clr", m_in2, '0);
        req = '0;
        request(0, 0, 32'd21, 32'd2);
        request(2, 2, 32'd5, 32'd6);
        @(negedge clk);
        reset_n = 1'b1;
        run_txn(1'b0, 0);
        run_txn(1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
